// File: rtl/synth_pkg.sv
// Shared voice-state type, envelope limit and the PS/2 scan-code to
// phase-increment table for the dual tone generator.
package synth_pkg;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_ATTACK  = 2'd1,
        V_SUSTAIN = 2'd2,
        V_RELEASE = 2'd3
    } voice_state_t;

    localparam logic [7:0] ENV_MAX = 8'd255;

    // Table increments are stored for a 24-bit accumulator and rescaled per voice.
    localparam int TABLE_W = 24;

    typedef struct packed {
        logic               valid;
        logic [TABLE_W-1:0] inc;
    } phase_entry_t;

    // C4..G5 chromatic: round(f * 2^24 / 48000).
    function automatic phase_entry_t phase_lookup(input logic [7:0] code);
        phase_entry_t e;
        e.valid = 1'b1;
        e.inc   = '0;
        case (code)
            8'h1C:   e.inc = 24'd91445;
            8'h1B:   e.inc = 24'd96882;
            8'h23:   e.inc = 24'd102643;
            8'h2B:   e.inc = 24'd108747;
            8'h34:   e.inc = 24'd115213;
            8'h33:   e.inc = 24'd122064;
            8'h3B:   e.inc = 24'd129322;
            8'h42:   e.inc = 24'd137012;
            8'h4B:   e.inc = 24'd145160;
            8'h4C:   e.inc = 24'd153791;
            8'h52:   e.inc = 24'd162936;
            8'h5B:   e.inc = 24'd172625;
            8'h4D:   e.inc = 24'd182890;
            8'h44:   e.inc = 24'd193765;
            8'h43:   e.inc = 24'd205287;
            8'h35:   e.inc = 24'd217494;
            8'h2C:   e.inc = 24'd230426;
            8'h24:   e.inc = 24'd244128;
            8'h1D:   e.inc = 24'd258645;
            8'h15:   e.inc = 24'd274025;
            default: e.valid = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One synth voice: key synchronizer, scan-code capture, ADSR-style FSM
// (no decay), 8-bit envelope and phase accumulator.
module tone_voice
    import synth_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter int ATK_STEP = 4,
    parameter int REL_STEP = 1
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         key_on,
    input  logic [7:0]   key_code,
    input  logic         step,
    output voice_state_t state,
    output logic [7:0]   env,
    output logic         acc_msb
);

    localparam logic [7:0] ATK    = 8'(ATK_STEP);
    localparam logic [7:0] REL    = 8'(REL_STEP);
    localparam int         WIDE_W = ACC_W + TABLE_W;

    // Rescale a 24-bit table increment to ACC_W bits with rounding.
    function automatic logic [ACC_W-1:0] scale_inc(input logic [TABLE_W-1:0] base);
        logic [WIDE_W-1:0] wide;
        wide = (WIDE_W'(base) << ACC_W) + (WIDE_W'(1) << (TABLE_W - 1));
        return wide[WIDE_W-1:TABLE_W];
    endfunction

    logic [1:0]   sync_q;
    logic         key_q;
    logic [7:0]   code_q;
    logic [7:0]   env_q, env_next;
    logic [ACC_W-1:0] acc_q, acc_key, acc_next, inc_step;
    voice_state_t state_q, state_key, state_next;
    phase_entry_t new_entry, cur_entry, inc_entry;
    logic         rise, fall;

    assign rise      = sync_q[1] & ~key_q;
    assign fall      = ~sync_q[1] & key_q;
    assign new_entry = phase_lookup(key_code);
    assign cur_entry = phase_lookup(code_q);

    // Key events resolve first; a coincident sample step then runs on the new state.
    always_comb begin
        state_key = state_q;
        acc_key   = acc_q;
        if (rise && new_entry.valid && (state_q == V_IDLE || state_q == V_RELEASE)) begin
            state_key = V_ATTACK;
            if (state_q == V_IDLE) acc_key = '0;
        end else if (fall && (state_q == V_ATTACK || state_q == V_SUSTAIN)) begin
            state_key = V_RELEASE;
        end

        inc_entry = rise ? new_entry : cur_entry;
        inc_step  = inc_entry.valid ? scale_inc(inc_entry.inc) : '0;

        state_next = state_key;
        env_next   = env_q;
        acc_next   = acc_key;
        if (step && state_key != V_IDLE) begin
            acc_next = acc_key + inc_step;
            case (state_key)
                V_ATTACK: begin
                    if (env_q >= ENV_MAX - ATK) begin
                        env_next   = ENV_MAX;
                        state_next = V_SUSTAIN;
                    end else begin
                        env_next = env_q + ATK;
                    end
                end
                V_RELEASE: begin
                    if (env_q <= REL) begin
                        env_next   = '0;
                        state_next = V_IDLE;
                    end else begin
                        env_next = env_q - REL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            key_q   <= 1'b0;
            code_q  <= 8'h00;
            env_q   <= '0;
            acc_q   <= '0;
            state_q <= V_IDLE;
        end else begin
            sync_q  <= {sync_q[0], key_on};
            key_q   <= sync_q[1];
            if (rise) code_q <= key_code;
            env_q   <= env_next;
            acc_q   <= acc_next;
            state_q <= state_next;
        end
    end

    assign state   = state_q;
    assign env     = env_q;
    assign acc_msb = acc_q[ACC_W-1];

endmodule

// File: rtl/dual_tone_gen.sv
// Two-voice square-wave synth: two tone_voice instances, a signed mixer and
// the two-stage sample pipeline (step voices, then register the sum).
module dual_tone_gen
    import synth_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter int ATK_STEP = 4,
    parameter int REL_STEP = 1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        key1_on,
    input  logic        key2_on,
    input  logic [7:0]  key1_code,
    input  logic [7:0]  key2_code,
    input  logic        sample_req,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic [1:0]  voice_active
);

    function automatic logic signed [15:0] voice_level(input voice_state_t st,
                                                       input logic [7:0] env,
                                                       input logic msb);
        logic signed [15:0] mag;
        mag = signed'({2'b00, env, 6'b000000});
        if (st == V_IDLE) return '0;
        return msb ? -mag : mag;
    endfunction

    voice_state_t       state1, state2;
    logic [7:0]         env1, env2;
    logic               msb1, msb2;
    logic               step, pend_q;
    logic signed [15:0] mix;

    // A request is dropped while the previous one is still waiting to be summed.
    assign step = sample_req & ~pend_q;

    tone_voice #(.ACC_W(ACC_W), .ATK_STEP(ATK_STEP), .REL_STEP(REL_STEP)) u_voice1 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .key_on  (key1_on),
        .key_code(key1_code),
        .step    (step),
        .state   (state1),
        .env     (env1),
        .acc_msb (msb1)
    );

    tone_voice #(.ACC_W(ACC_W), .ATK_STEP(ATK_STEP), .REL_STEP(REL_STEP)) u_voice2 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .key_on  (key2_on),
        .key_code(key2_code),
        .step    (step),
        .state   (state2),
        .env     (env2),
        .acc_msb (msb2)
    );

    // Peak per voice is 255<<6, so the sum never leaves 16-bit range.
    assign mix = voice_level(state1, env1, msb1) + voice_level(state2, env2, msb2);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            pend_q       <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else begin
            pend_q       <= step;
            sample_valid <= pend_q;
            if (pend_q) sample_data <= mix;
        end
    end

    assign voice_active = {state2 != V_IDLE, state1 != V_IDLE};

endmodule
